// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB4 requester. A valid/ready command port is turned
// into one APB SETUP + ACCESS transfer at a time, and the completion is
// reported back to the local controller as a one-cycle response pulse.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   -> an ACCESS phase that sees PREADY low for TIMEOUT cycles is
//                abandoned and reported with rsp_error=1, rsp_rdata=0
//   undefined -> ACCESS waits on PREADY indefinitely, TIMEOUT is ignored
//
// Parameters
//   ADDWIDTH   address width (PADDR, cmd_addr)
//   DATAWIDTH  data width, multiple of 8
//   TIMEOUT    max ACCESS wait cycles (only with APB_TIMEOUT_EN), >= 1
//
// Ports
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb           command payload
//   rsp_valid, rsp_rdata,
//   rsp_error                     one-cycle completion pulse + held payload
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PSTRB                 APB requester outputs (all registered)
//   PRDATA, PREADY, PSLVERR       APB completer inputs (used only in ACCESS)
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDWIDTH-1:0]      cmd_addr,
    input  logic [DATAWIDTH-1:0]     cmd_wdata,
    input  logic [DATAWIDTH/8-1:0]   cmd_strb,
    output logic                     rsp_valid,
    output logic [DATAWIDTH-1:0]     rsp_rdata,
    output logic                     rsp_error,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDWIDTH-1:0]      PADDR,
    output logic [DATAWIDTH-1:0]     PWDATA,
    output logic [DATAWIDTH/8-1:0]   PSTRB,
    input  logic [DATAWIDTH-1:0]     PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_accept;
    logic                     w_done;
    logic                     w_timeout;

    logic                     r_psel;
    logic                     r_penable;
    logic                     r_pwrite;
    logic [ADDWIDTH-1:0]      r_paddr;
    logic [DATAWIDTH-1:0]     r_pwdata;
    logic [DATAWIDTH/8-1:0]   r_pstrb;
    logic                     r_rspValid;
    logic [DATAWIDTH-1:0]     r_rspRdata;
    logic                     r_rspError;

    // cmd_ready is decoded from state so a command can be accepted in the
    // same cycle the previous response pulses; it is masked during reset.
    assign cmd_ready = (r_state == IDLE) && PRESETn;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == ACCESS) && (PREADY || w_timeout);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_waitCnt;

    // Counts PREADY-low ACCESS cycles; cleared in SETUP so every transfer
    // starts its ACCESS phase from zero.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_waitCnt <= '0;
        end else if (r_state == SETUP) begin
            r_waitCnt <= '0;
        end else if ((r_state == ACCESS) && !PREADY) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // The TIMEOUT-th stalled ACCESS cycle ends the transfer; a PREADY in
    // that same cycle still completes normally.
    assign w_timeout = (r_state == ACCESS) && !PREADY &&
                       (r_waitCnt == CW'(TIMEOUT - 1));
`else
    logic w_unusedTimeout;

    // Without the watchdog an ACCESS phase can only end on PREADY.
    assign w_timeout       = 1'b0;
    assign w_unusedTimeout = ^TIMEOUT;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // APB outputs and response are registered. Read commands drive zero
    // strobes and zero write data; the address phase values are left in
    // place after the transfer so the bus is quiet while idle.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspError <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            if (w_accept) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= cmd_write;
                r_paddr   <= cmd_addr;
                r_pwdata  <= cmd_write ? cmd_wdata : '0;
                r_pstrb   <= cmd_write ? cmd_strb  : '0;
            end
            if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end
            if (w_done) begin
                r_psel     <= 1'b0;
                r_penable  <= 1'b0;
                r_rspValid <= 1'b1;
                r_rspError <= PREADY ? PSLVERR : 1'b1;
                r_rspRdata <= (PREADY && !r_pwrite && !PSLVERR) ? PRDATA : '0;
            end
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_error = r_rspError;

endmodule
